// File: rtl/call_panel_scheduler.sv
// call_panel_scheduler: hall-call front end for the elevator controller.
// Synchronizes and filters the floor call buttons, lights one pending lamp
// per floor, queues new calls in arrival order and offers the queue head to
// the elevator core over a valid/ack handshake.
// Build option: define CALL_DEBOUNCE_EN to include the per-button debounce
// filter; without it the synchronizer output feeds edge detection directly.
module call_panel_scheduler #(
   parameter int FLOORS          = 4,
   parameter int FLOOR_W         = 2,
   parameter int DEPTH           = 4,
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FLOORS-1:0]      btn,
   input  logic [FLOOR_W-1:0]     cur_floor,
   input  logic                   arrived,
   output logic [FLOOR_W-1:0]     req_floor,
   output logic                   req_valid,
   input  logic                   req_ack,
   output logic [FLOORS-1:0]      pending,
   output logic [$clog2(DEPTH):0] queue_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (FLOOR_W != $clog2(FLOORS) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       DEBOUNCE_CYCLES < 1) begin : g_param_err
      $error("call_panel_scheduler: illegal parameter combination");
   end

   logic [FLOORS-1:0]  sync1_q, sync2_q;
   logic [FLOORS-1:0]  lvl_q, lvl_d;
   logic [FLOORS-1:0]  rise;
   logic [FLOORS-1:0]  accept;
   logic [FLOORS-1:0]  pending_q, pending_d;
   logic [FLOORS-1:0]  captured_q, captured_d;
   logic [FLOORS-1:0]  push_mask;
   logic [FLOOR_W-1:0] push_floor;
   logic [FLOOR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               issued_q, issued_d;
   logic               fifo_empty, fifo_full;
   logic [FLOOR_W-1:0] head_floor;
   logic               head_pend;
   logic               stale, push, pop;

   // Two-flop synchronizer for the asynchronous buttons.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

`ifdef CALL_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [FLOORS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

   // Filter: the level follows the synchronized button only after
   // DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      lvl_d    = lvl_q;
      db_cnt_d = db_cnt_q;
      for (int f = 0; f < FLOORS; f++) begin
         if (sync2_q[f] == lvl_q[f]) begin
            db_cnt_d[f] = '0;
         end else if (db_cnt_q[f] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            lvl_d[f]    = sync2_q[f];
            db_cnt_d[f] = '0;
         end else begin
            db_cnt_d[f] = db_cnt_q[f] + 1'b1;
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lvl_q    <= '0;
         db_cnt_q <= '0;
      end else begin
         lvl_q    <= lvl_d;
         db_cnt_q <= db_cnt_d;
      end
   end
`else
   // Without the filter the second synchronizer stage is the level; its
   // incoming value is the first stage, so a rise lands on the same edge.
   always_comb begin
      lvl_q = sync2_q;
      lvl_d = sync1_q;
   end
`endif

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign head_floor = mem_q[rd_ptr_q];
   assign head_pend  = pending_q[head_floor];

   // Once issued the head stays offered even if its lamp clears, so the
   // handshake remains stable until acknowledged.
   assign req_valid = !fifo_empty && (head_pend || issued_q);
   assign stale     = !fifo_empty && !head_pend && !issued_q;
   assign pop       = (req_valid && req_ack) || stale;
   assign push      = (captured_q != '0) && (!fifo_full || pop);

   // Lowest-numbered captured floor goes into the queue first.
   always_comb begin
      push_floor = '0;
      push_mask  = '0;
      for (int f = FLOORS - 1; f >= 0; f--) begin
         if (captured_q[f]) begin
            push_floor = FLOOR_W'(f);
            push_mask  = FLOORS'(1) << f;
         end
      end
   end

   // Capture new calls, retire the pushed one and clear the arrival floor.
   always_comb begin
      rise       = lvl_d & ~lvl_q;
      accept     = '0;
      pending_d  = pending_q;
      captured_d = captured_q;
      for (int f = 0; f < FLOORS; f++) begin
         accept[f] = rise[f] && !pending_q[f] &&
                     !(arrived && (cur_floor == FLOOR_W'(f)));
      end
      pending_d  = pending_d | accept;
      captured_d = (captured_d | accept) & ~(push ? push_mask : '0);
      if (arrived) begin
         pending_d[cur_floor]  = 1'b0;
         captured_d[cur_floor] = 1'b0;
      end
   end

   // Occupancy and issued-flag next state.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      issued_d = issued_q;
      if (pop) begin
         issued_d = 1'b0;
      end else if (req_valid) begin
         issued_d = 1'b1;
      end
   end

   // Lamp, capture, FIFO and handshake registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q  <= '0;
         captured_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         issued_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pending_q  <= pending_d;
         captured_q <= captured_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         if (push) begin
            mem_q[wr_ptr_q] <= push_floor;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign req_floor   = head_floor;
   assign pending     = pending_q;
   assign queue_count = count_q;

endmodule

// File: tb/tb_call_panel_scheduler.sv
// Directed bench for call_panel_scheduler: a DEPTH=4 instance for the main
// behaviour and a DEPTH=2 instance for queue saturation.
module tb_call_panel_scheduler;

`ifdef CALL_DEBOUNCE_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 2;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic [1:0] cur_floor;
   logic       arrived;
   logic       req_ack;
   logic       req_ack2;
   logic [1:0] req_floor, req_floor2;
   logic       req_valid, req_valid2;
   logic [3:0] pending, pending2;
   logic [2:0] queue_count;
   logic [1:0] queue_count2;

   int n_chk  = 0;
   int n_fail = 0;

   call_panel_scheduler #(.FLOORS(4), .FLOOR_W(2), .DEPTH(4), .DEBOUNCE_CYCLES(3)) u_dut (
      .clk(clk), .rst(rst), .btn(btn), .cur_floor(cur_floor), .arrived(arrived),
      .req_floor(req_floor), .req_valid(req_valid), .req_ack(req_ack),
      .pending(pending), .queue_count(queue_count)
   );

   call_panel_scheduler #(.FLOORS(4), .FLOOR_W(2), .DEPTH(2), .DEBOUNCE_CYCLES(3)) u_dut2 (
      .clk(clk), .rst(rst), .btn(btn), .cur_floor(cur_floor), .arrived(arrived),
      .req_floor(req_floor2), .req_valid(req_valid2), .req_ack(req_ack2),
      .pending(pending2), .queue_count(queue_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic arrive(input logic [1:0] f);
      cur_floor = f;
      arrived   = 1'b1;
      tick();
      arrived   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; btn = 4'b0100; cur_floor = 2'd0; arrived = 1'b0;
      req_ack = 1'b0; req_ack2 = 1'b0;

      // Reset held with a button pressed.
      ticks(3);
      chk("rst_pending", pending, 4'b0000);
      chk("rst_valid", req_valid, 1'b0);
      chk("rst_floor", req_floor, 2'd0);
      chk("rst_count", queue_count, 3'd0);
      rst = 1'b1;
      ticks(LAT - 1);
      chk("lat_early_pending", pending, 4'b0000);
      tick();
      chk("lat_pending", pending, 4'b0100);
      chk("lat_valid_before_push", req_valid, 1'b0);
      tick();
      chk("first_count", queue_count, 3'd1);
      chk("first_valid", req_valid, 1'b1);
      chk("first_floor", req_floor, 2'd2);
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      chk("first_pop_count", queue_count, 3'd0);
      chk("first_pop_valid", req_valid, 1'b0);
      chk("lamp_held_after_ack", pending, 4'b0100);
      btn = 4'b0000;
      ticks(LAT + 2);
      arrive(2'd2);
      chk("arrive_clear", pending, 4'b0000);

      // Simultaneous presses queue lowest floor first.
      btn = 4'b1011;
      ticks(LAT);
      chk("multi_pending", pending, 4'b1011);
      tick();
      chk("multi_head", req_floor, 2'd0);
      ticks(2);
      chk("multi_count", queue_count, 3'd3);
      req_ack = 1'b1;
      tick();
      chk("multi_seq1", req_floor, 2'd1);
      chk("multi_cnt1", queue_count, 3'd2);
      tick();
      chk("multi_seq3", req_floor, 2'd3);
      tick();
      chk("multi_drained", req_valid, 1'b0);
      req_ack = 1'b0;
      btn = 4'b0000;
      ticks(LAT + 2);
      arrive(2'd0); arrive(2'd1); arrive(2'd3);
      chk("multi_lamps_off", pending, 4'b0000);

      // Short pulse on floor 2.
      btn = 4'b0100;
      ticks(2);
      btn = 4'b0000;
      ticks(LAT + 4);
`ifdef CALL_DEBOUNCE_EN
      chk("glitch_pending", pending, 4'b0000);
      chk("glitch_count", queue_count, 3'd0);
`else
      chk("pulse_pending", pending, 4'b0100);
      chk("pulse_count", queue_count, 3'd1);
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      arrive(2'd2);
`endif

      // Repeated press of a pending floor is ignored.
      btn = 4'b0010;
      ticks(LAT + 1);
      chk("repress_first", queue_count, 3'd1);
      btn = 4'b0000;
      ticks(LAT + 2);
      btn = 4'b0010;
      ticks(LAT + 2);
      chk("repress_count", queue_count, 3'd1);
      chk("repress_floor", req_floor, 2'd1);
      btn = 4'b0000;
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      chk("repress_pop", queue_count, 3'd0);
      ticks(LAT + 2);
      arrive(2'd1);

      // Arrival while the request is outstanding keeps the handshake stable.
      btn = 4'b0100;
      ticks(LAT + 1);
      chk("hold_valid0", req_valid, 1'b1);
      btn = 4'b0000;
      cur_floor = 2'd2;
      arrived = 1'b1;
      tick();
      chk("hold_lamp", pending, 4'b0000);
      chk("hold_valid1", req_valid, 1'b1);
      chk("hold_floor1", req_floor, 2'd2);
      tick();
      arrived = 1'b0;
      chk("hold_valid2", req_valid, 1'b1);
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      chk("hold_pop_count", queue_count, 3'd0);
      chk("hold_pop_valid", req_valid, 1'b0);
      ticks(LAT + 2);

      // Stale entry dropped after its lamp clears.
      btn = 4'b1010;
      ticks(LAT + 2);
      chk("stale_count2", queue_count, 3'd2);
      chk("stale_head", req_floor, 2'd1);
      btn = 4'b0000;
      arrive(2'd3);
      chk("stale_lamp", pending, 4'b0010);
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      chk("stale_no_valid", req_valid, 1'b0);
      tick();
      chk("stale_dropped", queue_count, 3'd0);
      chk("stale_valid", req_valid, 1'b0);
      ticks(LAT + 2);
      arrive(2'd1);

      // Saturation on the DEPTH=2 instance, then reset mid-operation.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      btn = 4'b1111;
      ticks(LAT + 3);
      chk("sat_count", queue_count2, 2'd2);
      chk("sat_head", req_floor2, 2'd0);
      chk("sat_pending", pending2, 4'b1111);
      req_ack2 = 1'b1;
      tick();
      chk("sat_pushpop_count", queue_count2, 2'd2);
      chk("sat_pushpop_head", req_floor2, 2'd1);
      tick();
      chk("sat_head2", req_floor2, 2'd2);
      chk("sat_count_b", queue_count2, 2'd2);
      tick();
      chk("sat_head3", req_floor2, 2'd3);
      chk("sat_count1", queue_count2, 2'd1);
      tick();
      chk("sat_empty", queue_count2, 2'd0);
      req_ack2 = 1'b0;
      chk("deep_full", queue_count, 3'd4);
      rst = 1'b0;
      #1;
      chk("midrst_pending", pending, 4'b0000);
      chk("midrst_count", queue_count, 3'd0);
      chk("midrst_valid", req_valid, 1'b0);
      chk("midrst_floor", req_floor, 2'd0);
      chk("midrst_pending2", pending2, 4'b0000);
      btn = 4'b0000;
      tick();
      rst = 1'b1;
      ticks(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/call_panel_scheduler.md
Name: call_panel_scheduler

Overview:
- Hall-call front end for the elevator controller: samples raw floor call buttons, debounces them, lights per-floor pending lamps and queues floor requests in arrival order.
- Presents one request at a time to the elevator core over a valid/ack handshake.
- Clears each lamp when the car reports arrival at that floor.
- Runs on the divided elevator clock. It is the initiator side of the elevator's floor-request input.

Parameters:
- FLOORS, 4, number of floors and call buttons.
- FLOOR_W, 2, floor index width; must equal clog2(FLOORS).
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- DEBOUNCE_CYCLES, 3, number of consecutive stable samples needed to accept a level change.

Ports:
- clk  in  1  elevator clock (divided clock domain).
- rst  in  1  asynchronous, active-low reset.
- btn  in  FLOORS  raw call buttons, asynchronous, active-high.
- cur_floor  in  FLOOR_W  floor the car is currently at.
- arrived  in  1  car stopped with doors open at cur_floor; level, sampled every cycle.
- req_floor  out  FLOOR_W  requested floor (FIFO head).
- req_valid  out  1  req_floor is valid.
- req_ack  in  1  elevator accepts the request this cycle.
- pending  out  FLOORS  call lamps, one per floor.
- queue_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, async) clears: synchronizers, debounce counters, captured vector, pending, the FIFO (queue_count=0), req_valid, req_floor, and the issued flag. All outputs are 0 while in reset. Sequential operation begins at the first clk edge after rst goes high.
- Input path: each btn bit passes through a 2-flop synchronizer, then a debounce filter. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
- Capture: a rising edge on debounced bit f is accepted when pending[f]=0 and not (arrived=1 and cur_floor=f). On acceptance, pending[f] and captured[f] are set on that same edge. A press for a floor already pending, or for the floor the car is stopped at, is ignored.
- Push: each cycle, if captured≠0 and the FIFO is not full, the lowest-index set bit of captured is pushed and its captured bit is cleared. At most one push per cycle. Simultaneous presses are queued lowest floor first, one per cycle. When the FIFO is full, captured bits wait; no press is lost.
- Arrival: while arrived=1, pending[cur_floor] is cleared every cycle, and captured[cur_floor] is also cleared.
- Stale entry: if the FIFO head's pending bit is 0 and issued=0, the head is popped silently that cycle, with req_valid held at 0.
- Issue: req_valid=1 when the FIFO is not empty and either pending[head]=1 or issued=1. The issued flag sets on the first cycle req_valid is high.
- Handshake stability: once req_valid is high, req_valid and req_floor stay stable until req_ack is sampled high, even if arrival clears the lamp meanwhile.
- Pop: on req_valid&&req_ack the head is popped and issued is cleared. If the FIFO is still non-empty, a new head may be presented in the next cycle.
- req_ack while req_valid=0 is ignored.
- Simultaneous push and pop: queue_count is unchanged. A push is allowed when full if a pop occurs in the same cycle.
- Latency: debounced rise at edge E sets the lamp at E. The push happens at E+1, and req_valid is visible after E+1 when the queue was empty.
- Re-press of a floor whose lamp cleared while a stale entry is still queued creates a new entry. The older entry is then issued normally.
- FIFO pointers wrap modulo DEPTH. queue_count never exceeds DEPTH.

Optional Feature:
- Macro: CALL_DEBOUNCE_EN.
- Defined: the debounce filter is present as described above.
- Undefined: the filter is removed. The synchronizer output drives edge detection directly, and DEBOUNCE_CYCLES is unused. Lamp latency becomes 2 edges after btn rises.

Test Plan:
- Reset with btn=4'b0100 held: all outputs 0 during reset. After release and a stable press, pending=4'b0100 and req_floor=2 with req_valid=1, respecting sync+debounce latency (2+3 edges to lamp).
- btn=4'b1011 pressed in one cycle: pushes occur in order 0,1,3; queue_count reaches 3. With req_ack held high, req_floor sequence is 0,1,3.
- Glitch: btn[2] high for 2 cycles (DEBOUNCE_CYCLES=3): no lamp, no push. Press floor 1 twice while pending: only one queue entry.
- Press floor 2, then arrived=1 with cur_floor=2 before ack, while req_valid=1: lamp clears, req_valid/req_floor=2 held until req_ack, then the entry is popped.
- Queue floors 1 and 3 with req_ack=0; arrival at floor 3 clears pending[3]. After floor 1 is acked, the floor-3 entry is silently dropped: req_valid=0 and queue_count=0.
- DEPTH=2 with 4 simultaneous presses: queue_count saturates at 2, floors 2 and 3 wait in captured and are pushed as acks free space. Assert rst mid-operation: everything is 0 immediately.
